// File: rtl/cnn_conv_sequencer.sv
// Bus-mapped control/status front end for the CNN accelerator: register decode, configuration
// check, start/flush pulses and result-pop accounting with DONE/ERR flags and a level interrupt.
module cnn_conv_sequencer #(
    parameter int                        BUS_ADDR_WIDTH = 32,
    parameter int                        BUS_DATA_WIDTH = 64,
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        DIM_WIDTH      = 16,
    parameter int                        MAX_SIZE       = 4096,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                        clkIn,
    input  logic                        rstNIn,
    input  logic [BUS_ADDR_WIDTH-1:0]   addrIn,
    input  logic [BUS_DATA_WIDTH/8-1:0] wrEnIn,
    input  logic [BUS_DATA_WIDTH-1:0]   wrDataIn,
    input  logic                        rdEnIn,
    output logic [BUS_DATA_WIDTH-1:0]   rdDataOut,
    output logic                        rdValidOut,
    output logic                        irqOut,
    output logic                        accStartOut,
    output logic                        accFlushOut,
    output logic [DIM_WIDTH-1:0]        accFiltRowsOut,
    output logic [DIM_WIDTH-1:0]        accFiltColsOut,
    output logic [DIM_WIDTH-1:0]        accDataRowsOut,
    output logic [DIM_WIDTH-1:0]        accDataColsOut,
    input  logic [DATA_WIDTH-1:0]       accDataIn,
    input  logic                        accValidIn,
    output logic                        accReadyOut
);

    localparam int         PW         = 2 * DIM_WIDTH;
    localparam int         COL_LSB    = 16;
    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_STATUS = 3'd1;
    localparam logic [2:0] IDX_FILT   = 3'd2;
    localparam logic [2:0] IDX_DATA   = 3'd3;
    localparam logic [2:0] IDX_RESULT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_RUN
    } state_e;

    state_e                      state_q, state_d;
    logic                        irq_en_q, irq_en_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic [31:0]                 out_cnt_q, out_cnt_d;
    logic [31:0]                 exp_cnt_q, exp_cnt_d;
    logic [DIM_WIDTH-1:0]        filt_rows_q, filt_rows_d, filt_cols_q, filt_cols_d;
    logic [DIM_WIDTH-1:0]        data_rows_q, data_rows_d, data_cols_q, data_cols_d;
    logic                        flush_q;
    logic                        rd_valid_q;
    logic [BUS_DATA_WIDTH-1:0]   rd_data_q;

    logic                        hit, wr_hit, rd_hit, busy, pop;
    logic [2:0]                  idx;
    logic [BUS_DATA_WIDTH-1:0]   wmask, wdata_m, rd_mux;
    logic                        ctrl_wr, status_wr, filt_wr, data_wr, start_req, abort_req;
    logic [PW-1:0]               filt_area, data_area, exp_prod;
    logic                        cfg_ok;
    logic                        unused_bits;

    assign hit    = (addrIn[BUS_ADDR_WIDTH-1:6] == BASE_ADDR[BUS_ADDR_WIDTH-1:6]);
    assign idx    = addrIn[5:3];
    assign wr_hit = hit & (|wrEnIn);
    assign rd_hit = hit & rdEnIn;
    assign busy   = (state_q != S_IDLE);

    always_comb begin
        for (int b = 0; b < BUS_DATA_WIDTH / 8; b++) begin
            wmask[8*b +: 8] = {8{wrEnIn[b]}};
        end
    end
    assign wdata_m = wrDataIn & wmask;

    assign ctrl_wr   = wr_hit && (idx == IDX_CTRL);
    assign status_wr = wr_hit && (idx == IDX_STATUS);
    assign filt_wr   = wr_hit && (idx == IDX_FILT) && !busy;
    assign data_wr   = wr_hit && (idx == IDX_DATA) && !busy;
    assign start_req = ctrl_wr & wdata_m[0];
    assign abort_req = ctrl_wr & wdata_m[1];
    assign pop       = rd_hit && (idx == IDX_RESULT) && (state_q == S_RUN) && accValidIn;

    assign filt_area = PW'(filt_rows_q) * PW'(filt_cols_q);
    assign data_area = PW'(data_rows_q) * PW'(data_cols_q);
    assign exp_prod  = (PW'(data_rows_q) - PW'(filt_rows_q) + PW'(1))
                     * (PW'(data_cols_q) - PW'(filt_cols_q) + PW'(1));
    assign cfg_ok    = (filt_rows_q != '0) && (filt_cols_q != '0)
                    && (filt_rows_q <= data_rows_q) && (filt_cols_q <= data_cols_q)
                    && (filt_area <= PW'(MAX_SIZE)) && (data_area <= PW'(MAX_SIZE));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        err_d       = err_q;
        out_cnt_d   = out_cnt_q;
        exp_cnt_d   = exp_cnt_q;
        filt_rows_d = filt_rows_q;
        filt_cols_d = filt_cols_q;
        data_rows_d = data_rows_q;
        data_cols_d = data_cols_q;
        accStartOut = 1'b0;

        if (ctrl_wr && wrEnIn[0]) irq_en_d = wdata_m[2];
        if (status_wr && wdata_m[1]) done_d = 1'b0;
        if (status_wr && wdata_m[2]) err_d  = 1'b0;

        if (filt_wr) begin
            filt_rows_d = (filt_rows_q & ~wmask[DIM_WIDTH-1:0]) | wdata_m[DIM_WIDTH-1:0];
            filt_cols_d = (filt_cols_q & ~wmask[COL_LSB +: DIM_WIDTH]) | wdata_m[COL_LSB +: DIM_WIDTH];
        end
        if (data_wr) begin
            data_rows_d = (data_rows_q & ~wmask[DIM_WIDTH-1:0]) | wdata_m[DIM_WIDTH-1:0];
            data_cols_d = (data_cols_q & ~wmask[COL_LSB +: DIM_WIDTH]) | wdata_m[COL_LSB +: DIM_WIDTH];
        end

        // Flag sets below come after the W1C clears so a simultaneous set wins.
        if (abort_req) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_req) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (cfg_ok) begin
                        state_d   = S_LAUNCH;
                        exp_cnt_d = 32'(exp_prod);
                        out_cnt_d = '0;
                        err_d     = 1'b0;
                        done_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
                S_LAUNCH: begin
                    accStartOut = 1'b1;
                    state_d     = S_RUN;
                end
                S_RUN: begin
                    if (pop) begin
                        out_cnt_d = out_cnt_q + 32'd1;
                        if (out_cnt_q + 32'd1 == exp_cnt_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (idx)
            IDX_CTRL:   rd_mux[2] = irq_en_q;
            IDX_STATUS: begin
                rd_mux[2:0]     = {err_q, done_q, busy};
                rd_mux[32 +: 32] = out_cnt_q;
            end
            IDX_FILT: begin
                rd_mux[DIM_WIDTH-1:0]         = filt_rows_q;
                rd_mux[COL_LSB +: DIM_WIDTH]  = filt_cols_q;
            end
            IDX_DATA: begin
                rd_mux[DIM_WIDTH-1:0]         = data_rows_q;
                rd_mux[COL_LSB +: DIM_WIDTH]  = data_cols_q;
            end
            IDX_RESULT: begin
                rd_mux[DATA_WIDTH]     = pop;
                rd_mux[DATA_WIDTH-1:0] = pop ? accDataIn : '0;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state_q     <= S_IDLE;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_cnt_q   <= '0;
            exp_cnt_q   <= '0;
            filt_rows_q <= '0;
            filt_cols_q <= '0;
            data_rows_q <= '0;
            data_cols_q <= '0;
            flush_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= state_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_cnt_q   <= out_cnt_d;
            exp_cnt_q   <= exp_cnt_d;
            filt_rows_q <= filt_rows_d;
            filt_cols_q <= filt_cols_d;
            data_rows_q <= data_rows_d;
            data_cols_q <= data_cols_d;
            flush_q     <= abort_req;
            rd_valid_q  <= rd_hit;
            if (rd_hit) rd_data_q <= rd_mux;
        end
    end

    assign rdDataOut      = rd_data_q;
    assign rdValidOut     = rd_valid_q;
    assign irqOut         = done_q & irq_en_q;
    assign accFlushOut    = flush_q;
    assign accReadyOut    = pop;
    assign accFiltRowsOut = filt_rows_q;
    assign accFiltColsOut = filt_cols_q;
    assign accDataRowsOut = data_rows_q;
    assign accDataColsOut = data_cols_q;

    assign unused_bits = ^{addrIn[2:0], wmask[BUS_DATA_WIDTH-1:32], wdata_m[BUS_DATA_WIDTH-1:32]};

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Self-checking bench for cnn_conv_sequencer: directed scenarios plus randomized configurations
// checked against a transaction-level model of the register block and run accounting.
module tb_cnn_conv_sequencer;

    localparam int         MAXS     = 4096;
    localparam logic [2:0] I_CTRL   = 3'd0;
    localparam logic [2:0] I_STATUS = 3'd1;
    localparam logic [2:0] I_FILT   = 3'd2;
    localparam logic [2:0] I_DATA   = 3'd3;
    localparam logic [2:0] I_RESULT = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  wr_en = '0;
    logic [63:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [63:0] rd_data;
    logic        rd_valid, irq, acc_start, acc_flush, acc_ready;
    logic [15:0] f_rows, f_cols, d_rows, d_cols;
    logic [31:0] acc_data = '0;
    logic        acc_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int start_pulses = 0;
    int flush_pulses = 0;

    // Reference model state
    logic [31:0] m_filt, m_data;
    bit          m_busy, m_done, m_err, m_irq_en;
    int          m_cnt, m_exp;

    cnn_conv_sequencer dut (
        .clkIn          (clk),
        .rstNIn         (rst_n),
        .addrIn         (addr),
        .wrEnIn         (wr_en),
        .wrDataIn       (wr_data),
        .rdEnIn         (rd_en),
        .rdDataOut      (rd_data),
        .rdValidOut     (rd_valid),
        .irqOut         (irq),
        .accStartOut    (acc_start),
        .accFlushOut    (acc_flush),
        .accFiltRowsOut (f_rows),
        .accFiltColsOut (f_cols),
        .accDataRowsOut (d_rows),
        .accDataColsOut (d_cols),
        .accDataIn      (acc_data),
        .accValidIn     (acc_valid),
        .accReadyOut    (acc_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (acc_start) start_pulses++;
        if (acc_flush) flush_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        total++;
        assert (obs === expd) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
        end
    endtask

    function automatic bit cfg_ok();
        int fr, fc, dr, dc;
        fr = int'(m_filt[15:0]);  fc = int'(m_filt[31:16]);
        dr = int'(m_data[15:0]);  dc = int'(m_data[31:16]);
        return (fr != 0) && (fc != 0) && (fr <= dr) && (fc <= dc)
            && (fr * fc <= MAXS) && (dr * dc <= MAXS);
    endfunction

    function automatic int expected_outputs();
        return (int'(m_data[15:0]) - int'(m_filt[15:0]) + 1)
             * (int'(m_data[31:16]) - int'(m_filt[31:16]) + 1);
    endfunction

    task automatic model_reset();
        m_filt = '0; m_data = '0;
        m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0;
        m_cnt = 0;  m_exp = 0;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [63:0] d, input logic [7:0] be);
        @(negedge clk);
        addr = 32'(idx) << 3; wr_en = be; wr_data = d;
        @(negedge clk);
        wr_en = '0; wr_data = '0;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [63:0] d, output logic rdy);
        @(negedge clk);
        addr = 32'(idx) << 3; rd_en = 1'b1;
        #1 rdy = acc_ready;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
        check("rd_valid", rd_valid, 1'b1);
    endtask

    task automatic check_dims(input string tag);
        check({tag, "_filt"}, {f_cols, f_rows}, m_filt);
        check({tag, "_data"}, {d_cols, d_rows}, m_data);
    endtask

    task automatic check_status(input string tag);
        logic [63:0] d;
        logic        rdy;
        bus_read(I_STATUS, d, rdy);
        check(tag, d, {32'(m_cnt), 29'd0, m_err, m_done, m_busy});
        check({tag, "_irq"}, irq, m_done & m_irq_en);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_start"}, acc_start, 1'b0);
        check({tag, "_flush"}, acc_flush, 1'b0);
        check({tag, "_irq"},   irq, 1'b0);
        check({tag, "_ready"}, acc_ready, 1'b0);
        check({tag, "_rdv"},   rd_valid, 1'b0);
        check({tag, "_rdd"},   rd_data, 64'd0);
        check({tag, "_dims"},  {f_cols, f_rows, d_cols, d_rows}, 64'd0);
    endtask

    task automatic write_dim(input logic [2:0] idx, input int rows, input int cols,
                             input logic [7:0] be);
        logic [31:0] w, cur;
        w = {cols[15:0], rows[15:0]};
        bus_write(idx, {32'd0, w}, be);
        if (!m_busy) begin
            cur = (idx == I_FILT) ? m_filt : m_data;
            for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = w[8*b +: 8];
            if (idx == I_FILT) m_filt = cur; else m_data = cur;
        end
    endtask

    task automatic write_ctrl(input bit start, input bit abort);
        bus_write(I_CTRL, {61'd0, m_irq_en, abort, start}, 8'hFF);
    endtask

    task automatic w1c(input bit done, input bit err);
        bus_write(I_STATUS, {61'd0, err, done, 1'b0}, 8'hFF);
        if (done) m_done = 0;
        if (err)  m_err = 0;
    endtask

    // Issues START from idle and checks the start pulse appears exactly in the second cycle.
    task automatic do_start(input string tag);
        int s0;
        bit ok;
        ok = cfg_ok();
        s0 = start_pulses;
        write_ctrl(1'b1, 1'b0);
        check({tag, "_start_pre"}, acc_start, 1'b0);
        @(negedge clk);
        check({tag, "_start_pulse"}, acc_start, ok);
        @(negedge clk);
        check({tag, "_start_post"}, acc_start, 1'b0);
        check({tag, "_start_cnt"}, 64'(start_pulses - s0), 64'(ok));
        if (ok) begin
            m_busy = 1; m_cnt = 0; m_exp = expected_outputs(); m_done = 0; m_err = 0;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic pop(input bit valid, input string tag);
        logic [63:0] d;
        logic        rdy;
        logic [31:0] v;
        bit          hit;
        v   = $urandom;
        hit = valid && m_busy;
        acc_valid = valid;
        acc_data  = v;
        bus_read(I_RESULT, d, rdy);
        acc_valid = 1'b0;
        check({tag, "_ready"}, rdy, hit);
        check({tag, "_vbit"}, d[63:32], 64'(hit));
        if (hit) begin
            check({tag, "_data"}, d[31:0], v);
            m_cnt++;
            if (m_cnt == m_exp) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    task automatic run_cfg(input int fr, input int fc, input int dr, input int dc,
                           input string tag);
        int guard;
        write_dim(I_FILT, fr, fc, 8'hFF);
        write_dim(I_DATA, dr, dc, 8'hFF);
        check_dims(tag);
        do_start(tag);
        guard = 0;
        while (m_busy && guard < 2000) begin
            pop($urandom_range(0, 3) != 0, tag);
            guard++;
        end
        check_status({tag, "_end"});
        w1c(1'b1, 1'b1);
        check_status({tag, "_clr"});
    endtask

    initial begin
        logic [63:0] d;
        logic        rdy;
        int          f0, s0;
        int          cfg [6][4] = '{'{4, 2, 3, 8}, '{0, 3, 5, 5}, '{64, 64, 64, 64},
                                    '{1, 1, 4097, 1}, '{2, 3, 7, 4}, '{1, 1, 1, 1}};

        model_reset();
        repeat (3) @(negedge clk);
        check_quiet("reset_hold");
        rst_n = 1'b1;
        check_status("reset_status");
        bus_read(I_CTRL, d, rdy);
        check("reset_ctrl", d, 64'd0);

        // 3x3 filter over 5x5 data with interrupt enabled; one empty-FIFO read mid-run
        m_irq_en = 1;
        write_ctrl(1'b0, 1'b0);
        write_dim(I_FILT, 3, 3, 8'hFF);
        write_dim(I_DATA, 5, 5, 8'hFF);
        check_dims("t2");
        bus_read(I_FILT, d, rdy);
        check("t2_filt_rd", d, {32'd0, m_filt});
        do_start("t2");
        for (int i = 0; i < 4; i++) pop(1'b1, "t2_pop");
        pop(1'b0, "t4_empty");
        check_status("t4_status");
        for (int i = 0; i < 5; i++) pop(1'b1, "t2_pop");
        check_status("t2_done");
        w1c(1'b1, 1'b0);
        check_status("t2_done_clr");
        pop(1'b1, "idle_result");

        // Dimension mismatch is rejected without a launch, then ERR is cleared
        write_dim(I_FILT, 4, 2, 8'hFF);
        write_dim(I_DATA, 3, 8, 8'hFF);
        do_start("t3");
        check_status("t3_err");
        w1c(1'b0, 1'b1);
        check_status("t3_err_clr");

        // Byte-lane masked dimension write touches only the enabled byte
        write_dim(I_FILT, 16'hABCD, 16'h1234, 8'h01);
        check_dims("lane_mask");

        // Abort after 4 of 9 results
        write_dim(I_FILT, 3, 3, 8'hFF);
        write_dim(I_DATA, 5, 5, 8'hFF);
        do_start("t5");
        for (int i = 0; i < 4; i++) pop(1'b1, "t5_pop");
        f0 = flush_pulses;
        write_ctrl(1'b0, 1'b1);
        m_busy = 0;
        check("t5_flush_on", acc_flush, 1'b1);
        @(negedge clk);
        check("t5_flush_off", acc_flush, 1'b0);
        check("t5_flush_cnt", 64'(flush_pulses - f0), 64'd1);
        check_status("t5_status");
        write_dim(I_FILT, 2, 2, 8'hFF);
        check_dims("t5_dims");

        // START and ABORT together: abort wins
        s0 = start_pulses; f0 = flush_pulses;
        write_ctrl(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_no_start", 64'(start_pulses - s0), 64'd0);
        check("t6_flush_cnt", 64'(flush_pulses - f0), 64'd1);
        check_status("t6_status");

        // Dimension writes are ignored while busy
        write_dim(I_DATA, 3, 3, 8'hFF);
        do_start("t6b");
        write_dim(I_FILT, 7, 7, 8'hFF);
        write_dim(I_DATA, 9, 9, 8'hFF);
        check_dims("t6_busy_dims");
        write_ctrl(1'b0, 1'b1);
        m_busy = 0;
        check_status("t6b_abort");

        // Directed boundary table followed by random configurations
        for (int i = 0; i < 6; i++) run_cfg(cfg[i][0], cfg[i][1], cfg[i][2], cfg[i][3], "tab");
        for (int i = 0; i < 5; i++)
            run_cfg($urandom_range(1, 5), $urandom_range(1, 5),
                    $urandom_range(1, 9), $urandom_range(1, 9), "rnd");

        // Reset in the middle of a run
        write_dim(I_FILT, 1, 1, 8'hFF);
        write_dim(I_DATA, 3, 3, 8'hFF);
        do_start("t1");
        pop(1'b1, "t1_pop");
        pop(1'b1, "t1_pop");
        s0 = start_pulses; f0 = flush_pulses;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_quiet("t1_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("t1_no_pulses", 64'(start_pulses - s0 + flush_pulses - f0), 64'd0);
        check_dims("t1_dims");
        check_status("t1_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
